// File: rtl/dilated_tap_cache.sv
// Causal activation history for a dilated conv1d: stores each accepted vector in a ring
// and presents x[t-3*DIL], x[t-2*DIL], x[t-DIL], x[t] with a one-cycle out_v pulse.
module dilated_tap_cache #(
    parameter int W        = 16,
    parameter int D        = 8,
    parameter int DILATION = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_v,
    input  logic [D*W-1:0]   packed_in,
    output logic             in_ready,
    output logic [D*W-1:0]   packed_a0,
    output logic [D*W-1:0]   packed_a1,
    output logic [D*W-1:0]   packed_a2,
    output logic [D*W-1:0]   packed_a3,
    output logic             out_v,
    output logic [1:0]       dbg_state
);
    // Handshake: packed_in is taken on a rising edge where inp_v && in_ready; inp_v seen while
    // in_ready is low is dropped. out_v marks the single cycle in which new taps are presented.

    localparam int DEPTH = 3*DILATION + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] OFF1 = AW'(DILATION);
    localparam logic [AW-1:0] OFF2 = AW'(2*DILATION);
    localparam logic [AW-1:0] OFF3 = AW'(3*DILATION);
    localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, OUTPUT} state_t;

    state_t            state, state_n;
    logic [D*W-1:0]    mem [DEPTH];
    logic [D*W-1:0]    rd_data;
    logic [D*W-1:0]    cur, tap0, tap1;
    logic [AW-1:0]     wr_ptr, fill, rd_off, rd_addr;
    logic [1:0]        tap_cnt;

    // DEPTH is generally not a power of two, so wrap explicitly; LAST-off+1 avoids
    // needing DEPTH itself to fit in AW bits.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] ptr, input logic [AW-1:0] off);
        if (ptr >= off) return ptr - off;
        else            return ptr + (LAST - off) + AW'(1);
    endfunction

    always_comb begin
        rd_off = OFF1;
        if (state == WRITE)                       rd_off = OFF3;
        else if (state == READ && tap_cnt == 2'd0) rd_off = OFF2;
        rd_addr = tap_addr(wr_ptr, rd_off);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (inp_v) state_n = WRITE;
            WRITE:   state_n = READ;
            READ:    if (tap_cnt == 2'd2) state_n = OUTPUT;
            OUTPUT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // History RAM: not reset, stale entries are masked through fill.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE) mem[wr_ptr] <= cur;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            cur       <= '0;
            tap0      <= '0;
            tap1      <= '0;
            tap_cnt   <= '0;
            packed_a0 <= '0;
            packed_a1 <= '0;
            packed_a2 <= '0;
            packed_a3 <= '0;
        end else begin
            case (state)
                IDLE:  if (inp_v) cur <= packed_in;
                WRITE: tap_cnt <= 2'd0;
                READ: begin
                    tap_cnt <= tap_cnt + 2'd1;
                    if (tap_cnt == 2'd0) tap0 <= rd_data;
                    if (tap_cnt == 2'd1) tap1 <= rd_data;
                    if (tap_cnt == 2'd2) begin
                        // Taps land a cycle early so they are stable while out_v is high.
                        packed_a0 <= (fill >= OFF3) ? tap0 : '0;
                        packed_a1 <= (fill >= OFF2) ? tap1 : '0;
                        packed_a2 <= (fill >= OFF1) ? rd_data : '0;
                        packed_a3 <= cur;
                    end
                end
                OUTPUT: begin
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                    fill   <= (fill == OFF3) ? fill : fill + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_v     = (state == OUTPUT);
    assign dbg_state = state;

endmodule
